// File: rtl/gpi_sync_debounce.sv
// General-purpose input channel: pad synchronizer, settle sequencing after enable,
// debounce qualification with edge pulses and a sticky event flag.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// OFF    | pad receiver disabled, debounce counter cleared, level held
// SETTLE | receiver enabled, waiting for the synchronizer to refill
// RUN    | debounce active, level and edge pulses updated
module gpi_sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             PAD_DI_I,
  input  logic             EN_I,
  input  logic [1:0]       STE_CFG_I,
  input  logic [CNT_W-1:0] DB_LIMIT_I,
  input  logic             CLR_I,
  output logic             PAD_IE_O,
  output logic [1:0]       PAD_STE_O,
  output logic             LEVEL_O,
  output logic             RISE_O,
  output logic             FALL_O,
  output logic             EVT_STICKY_O
);

  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_d, rise_d, fall_d;
  logic               s;

  assign s = sync_q[SYNC_STAGES-1];

  // Pad idles high through its pull-up, so the chain resets to ones.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_DI_I};
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= ST_OFF;
      settle_q     <= '0;
      cnt_q        <= '0;
      LEVEL_O      <= 1'b1;
      RISE_O       <= 1'b0;
      FALL_O       <= 1'b0;
      EVT_STICKY_O <= 1'b0;
      PAD_STE_O    <= 2'b00;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      LEVEL_O      <= level_d;
      RISE_O       <= rise_d;
      FALL_O       <= fall_d;
      EVT_STICKY_O <= RISE_O | FALL_O | (EVT_STICKY_O & ~CLR_I);
      PAD_STE_O    <= STE_CFG_I;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    level_d  = LEVEL_O;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    PAD_IE_O = 1'b0;
    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        if (EN_I) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        PAD_IE_O = 1'b1;
        if (!EN_I) begin
          state_d = ST_OFF;
        end else if (settle_q == '0) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_RUN: begin
        PAD_IE_O = 1'b1;
        if (!EN_I) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (s != LEVEL_O) begin
          // >= rather than == so a lowered limit accepts immediately.
          if (cnt_q >= DB_LIMIT_I) begin
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gpi_sync_debounce.sv
// Bench for gpi_sync_debounce: directed scenarios then random traffic, all outputs
// compared every cycle against a run-length reference model.
module tb_gpi_sync_debounce;

  localparam int S = 2;
  localparam int W = 8;

  logic         CLK_I;
  logic         RST_I;
  logic         PAD_DI_I;
  logic         EN_I;
  logic [1:0]   STE_CFG_I;
  logic [W-1:0] DB_LIMIT_I;
  logic         CLR_I;
  logic         PAD_IE_O;
  logic [1:0]   PAD_STE_O;
  logic         LEVEL_O;
  logic         RISE_O;
  logic         FALL_O;
  logic         EVT_STICKY_O;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic       m_sync [0:S-1];
  logic       m_level, m_rise, m_fall, m_sticky, m_ie;
  logic [1:0] m_ste;
  int         m_en_age;
  int         m_run_len;

  gpi_sync_debounce #(.SYNC_STAGES(S), .CNT_W(W)) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .PAD_DI_I     (PAD_DI_I),
    .EN_I         (EN_I),
    .STE_CFG_I    (STE_CFG_I),
    .DB_LIMIT_I   (DB_LIMIT_I),
    .CLR_I        (CLR_I),
    .PAD_IE_O     (PAD_IE_O),
    .PAD_STE_O    (PAD_STE_O),
    .LEVEL_O      (LEVEL_O),
    .RISE_O       (RISE_O),
    .FALL_O       (FALL_O),
    .EVT_STICKY_O (EVT_STICKY_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: level follows the synchronized pad once it has disagreed for
  // limit+1 consecutive cycles while enabled long enough for the settle period.
  task automatic model_edge();
    logic s_pre, r_pre, f_pre;
    s_pre = m_sync[S-1];
    r_pre = m_rise;
    f_pre = m_fall;
    if (RST_I) begin
      for (int i = 0; i < S; i++) m_sync[i] = 1'b1;
      m_level = 1'b1; m_rise = 1'b0; m_fall = 1'b0; m_sticky = 1'b0;
      m_ste = 2'b00; m_ie = 1'b0; m_en_age = 0; m_run_len = 0;
      return;
    end
    m_ste    = STE_CFG_I;
    m_sticky = r_pre | f_pre | (m_sticky & ~CLR_I);
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    if (EN_I) begin
      if (m_en_age >= S + 2) begin
        if (s_pre != m_level) begin
          m_run_len++;
          if (m_run_len > int'(DB_LIMIT_I)) begin
            m_level   = s_pre;
            m_rise    = s_pre;
            m_fall    = ~s_pre;
            m_run_len = 0;
          end
        end else begin
          m_run_len = 0;
        end
      end
      if (m_en_age < 1000) m_en_age++;
    end else begin
      m_en_age  = 0;
      m_run_len = 0;
    end
    m_ie = EN_I;
    for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = PAD_DI_I;
  endtask

  task automatic step();
    @(posedge CLK_I);
    model_edge();
    #1;
    chk("level",  LEVEL_O,      m_level);
    chk("rise",   RISE_O,       m_rise);
    chk("fall",   FALL_O,       m_fall);
    chk("sticky", EVT_STICKY_O, m_sticky);
    chk("ie",     PAD_IE_O,     m_ie);
    chk("ste",    PAD_STE_O,    m_ste);
  endtask

  // Steps until the requested pulse is seen; n = edges taken, -1 on timeout.
  task automatic wait_pulse(input bit want_rise, input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if ((want_rise && RISE_O === 1'b1) || (!want_rise && FALL_O === 1'b1)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    RST_I = 1'b1; PAD_DI_I = 1'b1; EN_I = 1'b0; STE_CFG_I = 2'b10;
    DB_LIMIT_I = 8'd4; CLR_I = 1'b0;
    step();
    step();
    chk("rst_level",  LEVEL_O,      1'b1);
    chk("rst_ie",     PAD_IE_O,     1'b0);
    chk("rst_sticky", EVT_STICKY_O, 1'b0);
    chk("rst_ste",    PAD_STE_O,    2'b00);

    // enable with idle-high pad: receiver on after one edge, no activity
    RST_I = 1'b0; EN_I = 1'b1;
    step();
    chk("en_ie", PAD_IE_O, 1'b1);
    chk("ste_reg", PAD_STE_O, 2'b10);
    for (int i = 0; i < 6; i++) step();
    chk("idle_level", LEVEL_O, 1'b1);

    // L=4 falling edge: seven edges from pad change to level
    PAD_DI_I = 1'b0;
    wait_pulse(1'b0, 20, n);
    chk("fall_latency", n, 7);
    chk("fall_level", LEVEL_O, 1'b0);
    step();
    chk("fall_width", FALL_O, 1'b0);
    chk("sticky_set", EVT_STICKY_O, 1'b1);

    // glitch of 3 cycles is rejected at L=4
    PAD_DI_I = 1'b1;
    for (int i = 0; i < 3; i++) step();
    PAD_DI_I = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("glitch_level", LEVEL_O, 1'b0);

    // L=0 accepts on the first mismatching cycle
    DB_LIMIT_I = 8'd0; PAD_DI_I = 1'b1;
    wait_pulse(1'b1, 20, n);
    chk("l0_latency", n, 3);
    step();

    // limit lowered from 10 to 3 with six mismatches counted
    DB_LIMIT_I = 8'd10; PAD_DI_I = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("l10_no_fall", LEVEL_O, 1'b1);
    DB_LIMIT_I = 8'd3;
    step();
    chk("lower_fall",  FALL_O,  1'b1);
    chk("lower_level", LEVEL_O, 1'b0);

    // disable at cnt=2 of L=5 cancels without a pulse
    DB_LIMIT_I = 8'd5; PAD_DI_I = 1'b1;
    for (int i = 0; i < 4; i++) step();
    EN_I = 1'b0;
    step();
    chk("dis_ie",   PAD_IE_O, 1'b0);
    chk("dis_rise", RISE_O,   1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("dis_level", LEVEL_O, 1'b0);

    CLR_I = 1'b1;
    step();
    chk("clr_sticky", EVT_STICKY_O, 1'b0);
    CLR_I = 1'b0;

    // re-enable with pad already high and L=0: rise on the first RUN edge
    DB_LIMIT_I = 8'd0; EN_I = 1'b1;
    wait_pulse(1'b1, 20, n);
    chk("reen_latency", n, 5);
    CLR_I = 1'b1;
    step();
    chk("clr_vs_set", EVT_STICKY_O, 1'b1);
    step();
    chk("clr_after", EVT_STICKY_O, 1'b0);
    CLR_I = 1'b0;

    // reset mid-qualification aborts with no pulse
    DB_LIMIT_I = 8'd6; PAD_DI_I = 1'b0;
    for (int i = 0; i < 5; i++) step();
    RST_I = 1'b1;
    step();
    chk("rst_mid_fall",  FALL_O,  1'b0);
    chk("rst_mid_level", LEVEL_O, 1'b1);
    RST_I = 1'b0; PAD_DI_I = 1'b1; DB_LIMIT_I = 8'd2;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) PAD_DI_I = ~PAD_DI_I;
      if ($urandom_range(0, 99) == 0) DB_LIMIT_I = W'($urandom_range(0, 6));
      if (EN_I) EN_I = ($urandom_range(0, 149) != 0);
      else      EN_I = ($urandom_range(0, 3) == 0);
      CLR_I     = ($urandom_range(0, 19) == 0);
      STE_CFG_I = 2'($urandom_range(0, 3));
      RST_I     = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpi_sync_debounce.md
GPI_SYNC_DEBOUNCE -- requirements
Module: gpi_sync_debounce

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (legal range 2..4).
REQ-002 SHALL have parameter CNT_W, default 8, debounce counter width.
REQ-003 SHALL have port CLK_I  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port RST_I  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PAD_DI_I  input  1  raw pad receiver data (DI_O[0] of the pull-up input pad cell), asynchronous to CLK_I.
REQ-006 SHALL have port EN_I  input  1  channel enable.
REQ-007 SHALL have port STE_CFG_I  input  2  Schmitt-trigger configuration request.
REQ-008 SHALL have port DB_LIMIT_I  input  CNT_W  debounce qualification limit L, quasi-static.
REQ-009 SHALL have port CLR_I  input  1  sticky-event clear.
REQ-010 SHALL have port PAD_IE_O  output  1  pad input-enable, drives pad IE_I.
REQ-011 SHALL have port PAD_STE_O  output  2  drives pad STE_I.
REQ-012 SHALL have port LEVEL_O  output  1  debounced level.
REQ-013 SHALL have ports RISE_O / FALL_O  output  1 each  single-cycle edge pulses.
REQ-014 SHALL have port EVT_STICKY_O  output  1  latched "edge occurred" flag.

Function
REQ-015 SHALL pass PAD_DI_I through a SYNC_STAGES flop chain; chain output is s.
REQ-016 SHALL implement states OFF, SETTLE, RUN.
REQ-017 OFF: PAD_IE_O=0, counter held 0, LEVEL_O held, no pulses; EN_I=1 -> SETTLE.
REQ-018 SETTLE: PAD_IE_O=1, settle counter counts SYNC_STAGES+1 cycles, then -> RUN; stable level and debounce counter are not updated in SETTLE.
REQ-019 RUN: PAD_IE_O=1; each cycle with s!=LEVEL_O and cnt<L, cnt increments; with s!=LEVEL_O and cnt>=L, LEVEL_O<=s, cnt<=0, and the matching edge pulse is asserted; with s==LEVEL_O, cnt<=0.
REQ-020 Mismatch SHALL therefore persist L+1 consecutive RUN cycles before LEVEL_O changes; L=0 accepts on the first mismatching cycle.
REQ-021 A comparison of cnt>=L (not ==) SHALL apply, so lowering DB_LIMIT_I mid-count causes acceptance on the next mismatching cycle.
REQ-022 The counter SHALL never wrap; it saturates at L.
REQ-023 RISE_O SHALL be 1 for exactly the cycle in which LEVEL_O first reads 1 after 0; FALL_O likewise for 1->0; both SHALL be registered and never simultaneously 1.
REQ-024 End-to-end latency, pad edge to LEVEL_O, SHALL be SYNC_STAGES+L+1 cycles (RUN, stable input).
REQ-025 EN_I=0 in any state SHALL force -> OFF on the next edge, cancelling a pending qualification (cnt<=0) without a pulse.
REQ-026 EVT_STICKY_O SHALL set on RISE_O or FALL_O and clear on CLR_I; simultaneous set and clear SHALL leave it set.
REQ-027 PAD_STE_O SHALL be STE_CFG_I registered once, updated in all states.

Reset
REQ-028 While RST_I=1 at an edge: state=OFF, sync flops=1 (pull-up idle), LEVEL_O=1, cnt=0, settle counter=0, RISE_O=FALL_O=0, EVT_STICKY_O=0, PAD_IE_O=0, PAD_STE_O=2'b00.
REQ-029 Reset mid-qualification or mid-SETTLE SHALL abort with no pulse emitted.

Verification
REQ-030 Reset, EN_I=1, PAD_DI_I=1 constant -> PAD_IE_O=1 one cycle after EN_I, RUN after 3 cycles of SETTLE, LEVEL_O stays 1, no pulses.
REQ-031 L=4, RUN, PAD_DI_I 1->0 held -> LEVEL_O=0 and FALL_O=1 exactly 7 cycles later, FALL_O one cycle wide, EVT_STICKY_O=1 thereafter.
REQ-032 L=4, PAD_DI_I low for 3 cycles then high -> no LEVEL_O change, no pulse, cnt returns 0.
REQ-033 L=0 -> pad toggle yields LEVEL_O change after 3 cycles; L=10 with cnt=6, DB_LIMIT_I changed to 3 -> acceptance next mismatching cycle.
REQ-034 EN_I dropped at cnt=2 of L=5 -> OFF, PAD_IE_O=0, no pulse; CLR_I coincident with RISE_O -> EVT_STICKY_O stays 1.
